// File: rtl/rv32_core_pkg.sv
// Shared RV32I core definitions: reset/NOP defaults, fetch FSM states and a word-align helper.
package rv32_core_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register. Per-cycle priority: flush, then stall (hold), then load, else bubble.
module fetch_ifid_reg
    import rv32_core_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid
);

    // pc is left untouched on flush/bubble; only inst/valid define a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (!stall) begin
            if (load) begin
                valid <= 1'b1;
                inst  <= load_inst;
                pc    <= load_pc;
            end else begin
                valid <= 1'b0;
                inst  <= NOP_INST;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// RV32I fetch stage: PC register, one-outstanding imem handshake FSM, hold buffer, IF/ID register.
// Optional `FETCH_PERF_EN adds perf_fetched / perf_wait_cycles counters.
module fetch_pc_unit
    import rv32_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  npc,
    input  logic         redirect,
    output logic [31:0]  pc_plus4,
    input  logic         stall_f,
    input  logic         flush_d,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  inst_d,
    output logic [31:0]  pc_d,
    output logic         valid_d,
    output fetch_state_e dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_wait_cycles
`endif
);

    // Handshake: imem_req/imem_addr form a request that is accepted in the cycle imem_gnt=1;
    // exactly one imem_rvalid pulse (with imem_rdata) follows at least one cycle later, and no
    // new request is raised until that response has been consumed.

    fetch_state_e state, state_next;
    logic [31:0]  pc_f;
    logic [31:0]  hold_inst;
    logic [31:0]  load_inst;
    logic         advance;
    logic         load;
    logic         hold_we;

    assign pc_plus4  = pc_f + 32'd4;
    assign imem_req  = (state == REQ) && !rst;
    assign imem_addr = align_word(pc_f);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REQ;
            pc_f      <= RESET_PC;
            hold_inst <= NOP_INST;
        end else begin
            state <= state_next;
            if (advance) pc_f <= align_word(npc);
            if (hold_we) hold_inst <= imem_rdata;
        end
    end

    // Redirect always wins over stall_f for the PC; stale responses are swallowed in DROP.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        load       = 1'b0;
        load_inst  = hold_inst;
        hold_we    = 1'b0;
        case (state)
            REQ: begin
                if (imem_gnt) begin
                    advance    = redirect;
                    state_next = redirect ? DROP : WAIT;
                end else if (redirect) begin
                    advance = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        advance    = 1'b1;
                        state_next = REQ;
                    end else if (!stall_f) begin
                        load       = 1'b1;
                        load_inst  = imem_rdata;
                        advance    = 1'b1;
                        state_next = REQ;
                    end else begin
                        hold_we    = 1'b1;
                        state_next = HOLD;
                    end
                end else if (redirect) begin
                    advance    = 1'b1;
                    state_next = DROP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    advance    = 1'b1;
                    state_next = REQ;
                end else if (!stall_f) begin
                    load       = 1'b1;
                    advance    = 1'b1;
                    state_next = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid) state_next = REQ;
                if (redirect) advance = 1'b1;
            end
            default: state_next = REQ;
        endcase
    end

    fetch_ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_d),
        .stall     (stall_f),
        .load      (load),
        .load_inst (load_inst),
        .load_pc   (pc_f),
        .inst      (inst_d),
        .pc        (pc_d),
        .valid     (valid_d)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched     <= 32'h0;
            perf_wait_cycles <= 32'h0;
        end else begin
            if (load && !flush_d && !stall_f) perf_fetched <= perf_fetched + 32'd1;
            if (state == WAIT || state == DROP) perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the RV32I pipeline; sits directly downstream of the next-PC generator.
- Holds the fetch PC and returns PC+4 to the next-PC generator as its sequential-path input.
- Runs a one-outstanding request/grant/response handshake with instruction memory, then loads the IF/ID pipeline register.
- Handles stalls, redirects (branch/jal/jalr) and decode flushes, dropping in-flight fetches that have become stale.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- NOP_INST, 32'h0000_0013, value of inst_d whenever valid_d=0 (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- npc  in  32  next PC from the next-PC generator.
- redirect  in  1  npc is a taken branch/jal/jalr target.
- pc_plus4  out  32  pc_f+4, combinational, feeds the next-PC generator's PC input.
- stall_f  in  1  hazard unit: hold fetch and IF/ID.
- flush_d  in  1  clear IF/ID to a bubble.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals pc_f with [1:0]=00.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word, valid with rvalid.
- inst_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- valid_d  out  1  IF/ID holds a real instruction.

Behaviour:
Reset (async):
- pc_f=RESET_PC, state=REQ, valid_d=0, inst_d=NOP_INST, pc_d=0, hold buffer empty.
- imem_req rises in the first cycle after reset deasserts.

PC update:
- "advance" means pc_f<=npc with bits [1:0] cleared.
- pc_plus4 wraps modulo 2^32.

FSM: states REQ, WAIT, HOLD, DROP.
- REQ: imem_req=1.
  - gnt & !redirect -> WAIT.
  - gnt & redirect -> advance, DROP.
  - !gnt & redirect -> advance, stay REQ (address changes before acceptance).
- WAIT: imem_req=0.
  - rvalid & redirect -> discard word, advance, REQ.
  - rvalid & !stall_f -> load IF/ID {imem_rdata, pc_f, valid=1}, advance, REQ.
  - rvalid & stall_f -> capture word in hold buffer, HOLD.
  - !rvalid & redirect -> advance, DROP.
- HOLD: imem_req=0.
  - redirect -> discard buffer, advance, REQ.
  - !stall_f -> load IF/ID from buffer, advance, REQ.
- DROP: imem_req=0.
  - rvalid -> discard word, REQ.
  - redirect -> advance again, stay DROP (the pending response is still discarded).

IF/ID priority per cycle:
- flush_d: valid_d=0, inst_d=NOP_INST.
- else stall_f: hold all IF/ID outputs.
- else new word delivered: load it.
- else bubble: valid_d=0.

General rules:
- Redirect has priority over stall_f for pc_f.
- At most one request outstanding.
- Best-case throughput: one instruction per 2 cycles (REQ->WAIT->REQ).

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two outputs:
  - perf_fetched (32): increments on each IF/ID load with valid=1.
  - perf_wait_cycles (32): increments on each cycle in WAIT or DROP.
- Both counters wrap, reset to 0 asynchronously.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package rv32_core_pkg: RESET_PC default, NOP_INST, fetch state enum {REQ, WAIT, HOLD, DROP}.
- One sub-module, fetch_ifid_reg: IF/ID register implementing the flush/stall/load/bubble priority.
- FSM, PC register and hold buffer stay in fetch_pc_unit.

Test Plan:
- Reset, npc=pc_plus4, gnt same cycle, rvalid 1 cycle later, no stalls -> imem_addr 0,4,8 in consecutive REQ cycles; pc_d=0,4,8 with valid_d=1.
- Response arrives with stall_f=1 held 3 cycles -> state HOLD; inst_d/pc_d unchanged; word appears in IF/ID the cycle after stall_f falls; no extra imem_req meanwhile.
- Redirect to 0x100 the cycle after gnt for PC 0x8 -> DROP; word for 0x8 never reaches IF/ID; next imem_addr=0x100.
- gnt and redirect(npc=0x200) in the same REQ cycle, second redirect(0x300) while in DROP -> one response discarded; next imem_addr=0x300.
- flush_d and stall_f together with valid_d=1 -> valid_d=0, inst_d=0x00000013 next cycle.
- rst asserted mid-WAIT -> outputs return immediately to reset values; imem_addr=RESET_PC in the first cycle after release.
